// File: rtl/freg_wb_scheduler_if.sv
// ============================================================================
// freg_wb_scheduler_if
// Bundles the pipeline WB, FP-unit writeback, issue, decode and register-file
// write-port signals of the FP write-port scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface freg_wb_scheduler_if;
   logic        pipe_wb_en;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wb_data;
   logic        fpu_wb_valid;
   logic [4:0]  fpu_wb_rd;
   logic [31:0] fpu_wb_data;
   logic        fpu_wb_ready;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic        dec_valid;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic        hazard_stall;
   logic        force_stall;
   logic        rf_wb_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wb_data;
`ifdef FREG_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt;
`endif

   modport master (
      output pipe_wb_en, pipe_rd, pipe_wb_data,
      output fpu_wb_valid, fpu_wb_rd, fpu_wb_data,
      input  fpu_wb_ready,
      output iss_en, iss_rd,
      output dec_valid, dec_rs1, dec_rs2, dec_rd,
      input  hazard_stall, force_stall,
`ifdef FREG_CONFLICT_CNT_EN
      input  conflict_cnt,
`endif
      input  rf_wb_en, rf_rd, rf_wb_data
   );

   modport slave (
      input  pipe_wb_en, pipe_rd, pipe_wb_data,
      input  fpu_wb_valid, fpu_wb_rd, fpu_wb_data,
      output fpu_wb_ready,
      input  iss_en, iss_rd,
      input  dec_valid, dec_rs1, dec_rs2, dec_rd,
      output hazard_stall, force_stall,
`ifdef FREG_CONFLICT_CNT_EN
      output conflict_cnt,
`endif
      output rf_wb_en, rf_rd, rf_wb_data
   );
endinterface

`default_nettype wire

// File: rtl/freg_wb_scheduler.sv
// ============================================================================
// freg_wb_scheduler
// Shares the FP register-file write port between the WB stage and the
// long-latency FP unit; tracks busy registers and forces anti-starvation
// freezes. Optional macro FREG_CONFLICT_CNT_EN adds a blocked-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module freg_wb_scheduler #(
   parameter int MAX_WAIT = 4,
   parameter int NREG     = 32
) (
   input  wire logic           clk,
   input  wire logic           rst,
   freg_wb_scheduler_if.slave  bus
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_WAIT  = 2'd1;
   localparam logic [1:0] c_FORCE = 2'd2;
   localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [3:0]      r_wait_cnt;
   logic [3:0]      w_wait_cnt_nxt;
   logic            r_force_stall;
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   logic w_in_force;
   logic w_fpu_grant;
   logic w_pipe_grant;
   logic w_blocked;

   assign w_in_force   = (r_state == c_FORCE);
   // A pending FP result is dropped while reset is held.
   assign w_fpu_grant  = !rst && bus.fpu_wb_valid && (w_in_force || !bus.pipe_wb_en);
   assign w_pipe_grant = !w_in_force && bus.pipe_wb_en;
   assign w_blocked    = bus.fpu_wb_valid && !w_fpu_grant;

   assign bus.fpu_wb_ready = w_fpu_grant;
   assign bus.rf_wb_en     = w_fpu_grant || w_pipe_grant;
   assign bus.rf_rd        = w_fpu_grant ? bus.fpu_wb_rd   : bus.pipe_rd;
   assign bus.rf_wb_data   = w_fpu_grant ? bus.fpu_wb_data : bus.pipe_wb_data;
   assign bus.force_stall  = r_force_stall;

   assign bus.hazard_stall = bus.dec_valid &&
                             (r_busy[bus.dec_rs1] || r_busy[bus.dec_rs2] || r_busy[bus.dec_rd]);

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      if (w_in_force) begin
         w_state_nxt    = c_IDLE;
         w_wait_cnt_nxt = 4'd0;
      end else if (w_fpu_grant) begin
         w_state_nxt    = c_IDLE;
         w_wait_cnt_nxt = 4'd0;
      end else if (w_blocked) begin
         w_wait_cnt_nxt = r_wait_cnt + 4'd1;
         w_state_nxt    = (w_wait_cnt_nxt >= c_MAX_WAIT) ? c_FORCE : c_WAIT;
      end
   end

   // Set is applied after clear so a same-cycle reissue keeps the bit busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_fpu_grant) begin
         w_busy_nxt[bus.fpu_wb_rd] = 1'b0;
      end
      if (bus.iss_en) begin
         w_busy_nxt[bus.iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= c_IDLE;
         r_wait_cnt    <= 4'd0;
         r_force_stall <= 1'b0;
         r_busy        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_force_stall <= (w_state_nxt == c_FORCE);
         r_busy        <= w_busy_nxt;
      end
   end

`ifdef FREG_CONFLICT_CNT_EN
   logic [15:0] r_conflict_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_conflict_cnt <= 16'd0;
      end else if (w_blocked && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign bus.conflict_cnt = r_conflict_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/freg_wb_scheduler.md
Name: freg_wb_scheduler

Overview:
- Write-port scheduler and scoreboard for the single-write-port FP register file.
- Shares the one write port between two writers: the in-order pipeline WB stage and the long-latency FP unit (FDIV/FSQRT), which finishes out of order.
- Tracks FP registers with writes outstanding from the FP unit and raises a decode-stage hazard stall.
- Guarantees the FP unit cannot be starved by forcing a one-cycle pipeline freeze.

Parameters:
- MAX_WAIT, 4: FP-unit blocked cycles before a forced grant; range 1..15.
- NREG, 32: number of FP registers; index width is 5.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pipe_wb_en  in  1  WB stage requests an FP register write
- pipe_rd  in  5  WB destination index
- pipe_wb_data  in  32  WB write data
- fpu_wb_valid  in  1  FP unit result pending
- fpu_wb_rd  in  5  FP unit destination index
- fpu_wb_data  in  32  FP unit result
- fpu_wb_ready  out  1  FP unit result accepted this cycle
- iss_en  in  1  long-latency FP op issued this cycle
- iss_rd  in  5  destination of the issued op
- dec_valid  in  1  decode stage holds a valid FP-consuming instruction
- dec_rs1  in  5  decode FP source 1
- dec_rs2  in  5  decode FP source 2
- dec_rd  in  5  decode FP destination
- hazard_stall  out  1  decode must stall (RAW/WAW on a busy register)
- force_stall  out  1  pipeline must freeze and hold WB this cycle
- rf_wb_en  out  1  register file write enable
- rf_rd  out  5  register file write index
- rf_wb_data  out  32  register file write data
- conflict_cnt  out  16  [FREG_CONFLICT_CNT_EN only] blocked-cycle count

Behaviour:
- rst (synchronous, active-high): clears busy[NREG-1:0], clears wait_cnt, sets the FSM to IDLE.
- Registered outputs after reset: force_stall=0, conflict_cnt=0.
- Combinational outputs after reset follow their inputs as below.
- Write-port mux is combinational, zero latency.
- The register file samples rf_* on the same clock edge as the granted write.

FSM states and grants:
- IDLE/WAIT, pipe_wb_en=1: pipe is granted; rf_*=pipe_*; fpu_wb_ready=0.
- IDLE/WAIT, pipe_wb_en=0 and fpu_wb_valid=1: FP unit is granted; rf_*=fpu_*; fpu_wb_ready=1.
- IDLE/WAIT, no request: rf_wb_en=0.
- FORCE: force_stall=1; FP unit is granted unconditionally; pipe_wb_en is ignored. The pipeline holds its WB instruction and re-presents it next cycle.

FSM transitions and wait_cnt:
- Blocked cycle (fpu_wb_valid=1 and fpu_wb_ready=0): wait_cnt increments.
- Any FP grant: wait_cnt clears to 0.
- IDLE -> WAIT on the first blocked cycle.
- WAIT -> IDLE on an FP grant.
- WAIT -> FORCE when a blocked cycle brings wait_cnt to MAX_WAIT.
- FORCE -> IDLE after exactly 1 cycle; wait_cnt clears.
- FORCE with fpu_wb_valid=0 (FP unit flushed): treated as FORCE with no grant; return to IDLE.
- force_stall is a registered state decode; it is high only in FORCE.

Scoreboard:
- iss_en sets busy[iss_rd] at the next edge.
- fpu_wb_valid & fpu_wb_ready clears busy[fpu_wb_rd] at the next edge.
- Set and clear on the same index in the same cycle: set wins.
- hazard_stall = dec_valid & (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]).
- hazard_stall is combinational and ignores same-cycle completion (no bypass).
- Register 0 is a normal FP register with no hardwired-zero special case.
- A pipe write to a busy index is a protocol violation, prevented upstream by hazard_stall. There is no assertion in RTL.

Reset mid-operation:
- A pending FP result is dropped; fpu_wb_ready=0 during the reset cycle.
- All busy bits clear.

Optional Feature:
- Macro FREG_CONFLICT_CNT_EN.
- Defined: conflict_cnt is a 16-bit counter that increments once per blocked cycle, saturates at 0xFFFF and clears on rst.
- Undefined: the port and counter are absent; the FSM and all other behaviour are identical.

Test Plan:
- Reset, then no requests -> rf_wb_en=0, force_stall=0, hazard_stall=0, busy all 0.
- pipe_wb_en=1, pipe_rd=3, data 0x3F800000, with fpu_wb_valid=1, rd=7 -> cycle 1 writes f3 and fpu_wb_ready=0; next cycle with pipe idle, f7 is written and fpu_wb_ready=1.
- pipe_wb_en held 1 continuously with fpu_wb_valid=1 and MAX_WAIT=4 -> force_stall=1 on cycle 5, f-unit data written that cycle, force_stall=0 on cycle 6, pipe resumes.
- iss_en=1, iss_rd=5, then decode dec_rs2=5 with dec_valid=1 -> hazard_stall=1 until the cycle after FP unit writes f5; then 0.
- iss_en rd=9 in the same cycle as FP grant on rd=9 -> busy[9]=1 afterwards; hazard_stall=1 for decode reading f9.
- rst asserted during WAIT with wait_cnt=3 -> next cycle FSM IDLE, busy cleared, force_stall=0, conflict_cnt=0 (macro defined).
